// File: rtl/mem_access_ctrl_if.sv
// mem_access_ctrl_if: CPU request/response and RAM strobe/ready signals of the access controller
interface mem_access_ctrl_if #(
  parameter int ADDR_W = 16,
  parameter int DATA_W = 16
);
  logic              req;
  logic              we;
  logic [ADDR_W-1:0] addr;
  logic [DATA_W-1:0] wdata;
  logic              busy;
  logic              done;
  logic              err;
  logic [DATA_W-1:0] rdata;
  logic [ADDR_W-1:0] MAR;
  logic [DATA_W-1:0] MDR_in;
  logic              read;
  logic              write;
  logic              R;
  logic [DATA_W-1:0] MDR;
  modport master (
    input  req, we, addr, wdata, R, MDR,
    output busy, done, err, rdata, MAR, MDR_in, read, write
  );
  modport slave (
    output req, we, addr, wdata, R, MDR,
    input  busy, done, err, rdata, MAR, MDR_in, read, write
  );
endinterface

// File: rtl/mem_access_ctrl.sv
// mem_access_ctrl: CPU load/store to four-phase RAM handshake, with timeout abort
module mem_access_ctrl #(
  parameter int ADDR_W  = 16,
  parameter int DATA_W  = 16,
  parameter int TIMEOUT = 64
) (
  input logic              clock,
  input logic              reset_n,
  mem_access_ctrl_if.master bus
);
  localparam int CW = $clog2(TIMEOUT);
  localparam logic [CW-1:0] LAST = CW'(TIMEOUT - 1);
  typedef enum logic [1:0] {IDLE, WAIT_ACK, WAIT_REL} state_t;
  state_t            state_q, state_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic              busy_q, busy_d, done_q, done_d, err_q, err_d;
  logic              read_q, read_d, write_q, write_d, aborted_q, aborted_d;
  logic [ADDR_W-1:0] mar_q, mar_d;
  logic [DATA_W-1:0] mdr_in_q, mdr_in_d, rdata_q, rdata_d;
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    busy_d    = busy_q;
    done_d    = 1'b0;
    err_d     = 1'b0;
    read_d    = read_q;
    write_d   = write_q;
    aborted_d = aborted_q;
    mar_d     = mar_q;
    mdr_in_d  = mdr_in_q;
    rdata_d   = rdata_q;
    case (state_q)
      IDLE: if (bus.req) begin
        mar_d    = bus.addr;
        mdr_in_d = bus.wdata;
        read_d   = ~bus.we;
        write_d  = bus.we;
        cnt_d    = '0;
        busy_d   = 1'b1;
        state_d  = WAIT_ACK;
      end
      WAIT_ACK: begin
        cnt_d = cnt_q + 1'b1;
        // ack wins over a timeout landing on the same edge
        if (bus.R || cnt_q == LAST) begin
          read_d    = 1'b0;
          write_d   = 1'b0;
          cnt_d     = '0;
          aborted_d = ~bus.R;
          rdata_d   = (bus.R && read_q) ? bus.MDR : rdata_q;
          state_d   = WAIT_REL;
        end
      end
      WAIT_REL: begin
        cnt_d = cnt_q + 1'b1;
        if (!bus.R || cnt_q == LAST) begin
          done_d  = 1'b1;
          err_d   = aborted_q | bus.R;
          busy_d  = 1'b0;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
      read_q    <= 1'b0;
      write_q   <= 1'b0;
      aborted_q <= 1'b0;
      mar_q     <= '0;
      mdr_in_q  <= '0;
      rdata_q   <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      err_q     <= err_d;
      read_q    <= read_d;
      write_q   <= write_d;
      aborted_q <= aborted_d;
      mar_q     <= mar_d;
      mdr_in_q  <= mdr_in_d;
      rdata_q   <= rdata_d;
    end
  end
  assign bus.busy   = busy_q;
  assign bus.done   = done_q;
  assign bus.err    = err_q;
  assign bus.rdata  = rdata_q;
  assign bus.MAR    = mar_q;
  assign bus.MDR_in = mdr_in_q;
  assign bus.read   = read_q;
  assign bus.write  = write_q;
endmodule

// File: tb/tb_mem_access_ctrl.sv
// tb_mem_access_ctrl: scoreboard bench with a behavioural four-phase RAM responder
module tb_mem_access_ctrl;
  localparam int AW = 16;
  localparam int DW = 16;
  localparam int TO = 8;
  typedef struct packed {logic err; logic [DW-1:0] rdata;} exp_t;
  typedef enum int {NORMAL, DEAD, STUCK} ram_mode_t;
  logic clock = 1'b0;
  logic reset_n = 1'b0;
  always #5 clock = ~clock;
  mem_access_ctrl_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();
  mem_access_ctrl #(.ADDR_W(AW), .DATA_W(DW), .TIMEOUT(TO)) dut (
    .clock(clock), .reset_n(reset_n), .bus(bus)
  );
  exp_t      sb[$];
  int        n_cmp = 0, n_bad = 0, n_done = 0, n_push = 0;
  logic [DW-1:0] mem [0:65535];
  logic [DW-1:0] ref_mem [0:65535];
  logic [DW-1:0] exp_rd = '0;
  ram_mode_t mode = NORMAL;
  int        ack_lat = 2, rel_lat = 1, dly = 0, rel = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // RAM: raise R ack_lat cycles after a strobe, drop it rel_lat cycles after the strobe falls
  always @(negedge clock) begin
    if (!reset_n) begin
      bus.R = 1'b0; dly = 0; rel = 0;
    end else if (mode == DEAD) begin
      bus.R = 1'b0;
    end else if (!bus.R) begin
      rel = 0;
      if (bus.read || bus.write) begin
        if (dly == ack_lat) begin
          bus.R = 1'b1; dly = 0;
          if (bus.read) bus.MDR = mem[bus.MAR];
          else mem[bus.MAR] = bus.MDR_in;
        end else dly++;
      end else dly = 0;
    end else if (!(bus.read || bus.write) && mode != STUCK) begin
      if (rel == rel_lat) begin bus.R = 1'b0; rel = 0; end
      else rel++;
    end
  end

  always @(negedge clock) if (reset_n) begin
    check("rw_excl", 32'(bus.read & bus.write), 0);
    check("err_only_with_done", 32'(bus.err & ~bus.done), 0);
    if (bus.done) begin
      exp_t e;
      n_done++;
      check("busy_at_done", 32'(bus.busy), 0);
      if (sb.size() == 0) check("unexpected_done", 32'(bus.done), 0);
      else begin
        e = sb.pop_front();
        check("err", 32'(bus.err), 32'(e.err));
        check("rdata", 32'(bus.rdata), 32'(e.rdata));
      end
    end
  end

  task automatic issue(input logic w, input logic [AW-1:0] a, input logic [DW-1:0] d, input bit accept);
    bus.req = 1'b1; bus.we = w; bus.addr = a; bus.wdata = d;
    if (accept) begin
      exp_t e;
      if (w) ref_mem[a] = d;
      else if (mode != DEAD) exp_rd = ref_mem[a];
      e.err = (mode != NORMAL);
      e.rdata = exp_rd;
      sb.push_back(e);
      n_push++;
    end
    @(posedge clock);
    #1 bus.req = 1'b0;
  endtask

  task automatic wait_done(input int budget);
    for (int i = 0; i < budget && !bus.done; i++) @(negedge clock);
    check("done_seen", 32'(bus.done), 1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    bus.req = 1'b0; bus.we = 1'b0; bus.addr = '0; bus.wdata = '0; bus.R = 1'b0; bus.MDR = '0;
    mem[16'h3020] = 16'h0001; ref_mem[16'h3020] = 16'h0001;
    repeat (2) @(posedge clock);
    #1;
    check("rst_busy", 32'(bus.busy), 0);
    check("rst_rw", 32'({bus.read, bus.write}), 0);
    check("rst_done_err", 32'({bus.done, bus.err}), 0);
    check("rst_mar", 32'(bus.MAR), 0);
    check("rst_mdr_in", 32'(bus.MDR_in), 0);
    check("rst_rdata", 32'(bus.rdata), 0);
    @(negedge clock) reset_n = 1'b1;
    // plain read
    @(negedge clock) issue(1'b0, 16'h3020, '0, 1);
    check("t1_read", 32'(bus.read), 1);
    check("t1_mar", 32'(bus.MAR), 32'h3020);
    check("t1_busy", 32'(bus.busy), 1);
    wait_done(40);
    @(negedge clock);
    check("t1_busy_after", 32'(bus.busy), 0);
    check("t1_done_one_cycle", 32'(bus.done), 0);
    // write then read back
    @(negedge clock) issue(1'b1, 16'h3100, 16'hBEEF, 1);
    check("t2_write", 32'(bus.write), 1);
    check("t2_no_read", 32'(bus.read), 0);
    check("t2_mdr_in", 32'(bus.MDR_in), 32'hBEEF);
    wait_done(40);
    @(negedge clock) issue(1'b0, 16'h3100, '0, 1);
    wait_done(40);
    // dead RAM: strobe held TIMEOUT cycles, then error
    @(negedge clock) mode = DEAD;
    @(negedge clock) issue(1'b0, 16'h3020, '0, 1);
    repeat (TO - 1) @(posedge clock);
    #1 check("t3_read_held", 32'(bus.read), 1);
    @(posedge clock);
    #1 check("t3_read_drop", 32'(bus.read), 0);
    check("t3_no_done_yet", 32'(bus.done), 0);
    wait_done(4);
    mode = NORMAL;
    // req while busy ignored, req on done cycle accepted
    @(negedge clock) ack_lat = 4;
    issue(1'b0, 16'h3020, '0, 1);
    @(negedge clock) issue(1'b0, 16'h3001, '0, 0);
    check("t4_mar_kept", 32'(bus.MAR), 32'h3020);
    check("t4_read_kept", 32'(bus.read), 1);
    wait_done(40);
    issue(1'b0, 16'h3100, '0, 1);
    check("t4_b2b_read", 32'(bus.read), 1);
    check("t4_b2b_mar", 32'(bus.MAR), 32'h3100);
    wait_done(40);
    // reset in the middle of an access
    @(negedge clock) issue(1'b0, 16'h3100, '0, 1);
    check("t5_read", 32'(bus.read), 1);
    @(negedge clock) reset_n = 1'b0;
    void'(sb.pop_back());
    n_push--;
    exp_rd = '0;
    @(posedge clock);
    #1;
    check("t5_rw", 32'({bus.read, bus.write}), 0);
    check("t5_busy", 32'(bus.busy), 0);
    check("t5_mar", 32'(bus.MAR), 0);
    check("t5_done_err", 32'({bus.done, bus.err}), 0);
    check("t5_rdata", 32'(bus.rdata), 0);
    @(negedge clock) reset_n = 1'b1;
    repeat (3) @(negedge clock);
    issue(1'b0, 16'h3020, '0, 1);
    wait_done(40);
    // RAM stuck ready after ack
    @(negedge clock) mode = STUCK;
    ack_lat = 1;
    issue(1'b0, 16'h3100, '0, 1);
    wait_done(40);
    @(negedge clock);
    check("t6_idle", 32'(bus.busy), 0);
    mode = NORMAL;
    repeat (4) @(negedge clock);
    issue(1'b0, 16'h3020, '0, 1);
    wait_done(40);
    repeat (2) @(negedge clock);
    check("sb_empty", 32'(sb.size()), 0);
    check("done_count", 32'(n_done), 32'(n_push));
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
